// File: rtl/fifo_pkg.sv
// Shared definitions for the asynchronous FIFO: default sizes, the FWFT output states
// and Gray/binary conversion helpers used by both clock domains.
package fifo_pkg;

  localparam int FIFO_ADDRSIZE = 4;
  localparam int FIFO_DATASIZE = 8;

  // Conversions are written once at this width; callers zero-extend narrower pointers
  // and cast the result back. Leading zeros do not disturb either conversion.
  localparam int PTR_MAX_W = 32;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

  function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] gray);
    logic [PTR_MAX_W-1:0] bin;
    bin[PTR_MAX_W-1] = gray[PTR_MAX_W-1];
    for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/sync_w2r.sv
// Two-flop synchronizer for a Gray pointer crossing into the local clock domain.
// Used as sync_w2r on the read side and as sync_r2w on the write side.
module sync_w2r
  import fifo_pkg::*;
#(
  parameter int ADDRSIZE = FIFO_ADDRSIZE
) (
  input  logic                rclk,
  input  logic                rrst,
  input  logic [ADDRSIZE:0]   ptr,
  output logic [ADDRSIZE:0]   ptr_sync
);

  logic [ADDRSIZE:0] q1;

  // No logic between the stages so the first flop has a full cycle to resolve.
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      q1       <= '0;
      ptr_sync <= '0;
    end else begin
      q1       <= ptr;
      ptr_sync <= q1;
    end
  end

endmodule

// File: rtl/fifo_rptr_fwft.sv
// Read-side controller of the async FIFO with a first-word-fall-through output register.
// Define FIFO_RLEVEL_EN to build the rlevel occupancy counter; otherwise rlevel is 0.
module fifo_rptr_fwft
  import fifo_pkg::*;
#(
  parameter int ADDRSIZE = FIFO_ADDRSIZE,
  parameter int DATASIZE = FIFO_DATASIZE
) (
  input  logic                  rclk,
  input  logic                  rrst,
  input  logic [ADDRSIZE:0]     wptr,
  input  logic [DATASIZE-1:0]   rdata_mem,
  output logic [ADDRSIZE-1:0]   raddr,
  output logic [ADDRSIZE:0]     rptr,
  output logic                  rempty,
  output logic [DATASIZE-1:0]   dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic [ADDRSIZE:0]     rlevel
);

  localparam int PW = ADDRSIZE + 1;

  logic [ADDRSIZE:0] rq2_wptr;
  logic [ADDRSIZE:0] rbin;
  logic [ADDRSIZE:0] rbinnext;
  logic [ADDRSIZE:0] rgraynext;
  logic              rpop;
  logic              dout_load;
  out_state_e        out_state;
  out_state_e        out_next;

  sync_w2r #(.ADDRSIZE(ADDRSIZE)) u_sync_w2r (
    .rclk     (rclk),
    .rrst     (rrst),
    .ptr      (wptr),
    .ptr_sync (rq2_wptr)
  );

  // Handshake: a word moves out when dout_valid & dout_ready at a rising rclk edge;
  // while dout_valid=1 and dout_ready=0, dout and dout_valid are held unchanged.
  assign dout_valid = (out_state == OUT_FULL);
  assign rpop       = ~rempty & (~dout_valid | dout_ready);

  assign rbinnext  = rbin + {{ADDRSIZE{1'b0}}, rpop};
  assign rgraynext = PW'(bin2gray(PTR_MAX_W'(rbinnext)));
  assign raddr     = rbin[ADDRSIZE-1:0];

  // Comparing against the next Gray value flags empty on the same edge that pops the last word.
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      rbin   <= '0;
      rptr   <= '0;
      rempty <= 1'b1;
    end else begin
      rbin   <= rbinnext;
      rptr   <= rgraynext;
      rempty <= (rgraynext == rq2_wptr);
    end
  end

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      out_state <= OUT_EMPTY;
      dout      <= '0;
    end else begin
      out_state <= out_next;
      if (dout_load) begin
        dout <= rdata_mem;
      end
    end
  end

  always_comb begin
    out_next  = out_state;
    dout_load = 1'b0;
    case (out_state)
      OUT_EMPTY: begin
        if (rpop) begin
          dout_load = 1'b1;
          out_next  = OUT_FULL;
        end
      end
      OUT_FULL: begin
        if (dout_ready) begin
          if (rpop) begin
            dout_load = 1'b1;
          end else begin
            out_next = OUT_EMPTY;
          end
        end
      end
      default: out_next = OUT_EMPTY;
    endcase
  end

`ifdef FIFO_RLEVEL_EN
  logic [ADDRSIZE:0] wbin_sync;

  // Counts words still in memory; the word parked in dout was already popped.
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      wbin_sync <= '0;
      rlevel    <= '0;
    end else begin
      wbin_sync <= PW'(gray2bin(PTR_MAX_W'(rq2_wptr)));
      rlevel    <= wbin_sync - rbinnext;
    end
  end
`else
  assign rlevel = '0;
`endif

endmodule

// File: tb/tb_fifo_rptr_fwft.sv
// Directed and randomized bench for fifo_rptr_fwft: the bench plays the write side and the
// memory, and a queue of written-but-unaccepted words is the reference for the read side.
module tb_fifo_rptr_fwft;

  logic       rclk = 1'b0;
  logic       rrst;
  logic [4:0] wptr;
  logic [7:0] rdata_mem;
  logic [3:0] raddr;
  logic [4:0] rptr;
  logic       rempty;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready;
  logic [4:0] rlevel;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mem[16];
  logic [4:0] wcnt;
  bit         prev_stall;
  logic [7:0] prev_dout;

  int         n_wr;
  bit         saw_wrap;
  int         msb_toggles;
  logic [3:0] prev_raddr;
  logic       prev_msb;
  int         unread;

  fifo_rptr_fwft #(.ADDRSIZE(4), .DATASIZE(8)) dut (
    .rclk       (rclk),
    .rrst       (rrst),
    .wptr       (wptr),
    .rdata_mem  (rdata_mem),
    .raddr      (raddr),
    .rptr       (rptr),
    .rempty     (rempty),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .rlevel     (rlevel)
  );

  // clock / memory model
  initial forever #5 rclk = ~rclk;
  assign rdata_mem = mem[raddr];

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [4:0] gray5(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] exp_level(input int unread_mem);
`ifdef FIFO_RLEVEL_EN
    return 32'(unread_mem);
`else
    return 32'd0 & 32'(unread_mem);
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver: write one word into memory and advance the Gray write pointer
  task automatic wr_word(input logic [7:0] d);
    mem[wcnt[3:0]] = d;
    wcnt = wcnt + 5'd1;
    wptr = gray5(wcnt);
    exp_q.push_back(d);
  endtask

  // called at a falling edge: scoreboard the upcoming handshake, drive ready, advance a cycle
  task automatic cycle(input bit rdy);
    logic [7:0] exp;
    if (dout_valid === 1'b1) check("spurious_valid", 32'(exp_q.size() != 0), 32'd1);
    if (prev_stall) begin
      check("stall_valid", 32'(dout_valid), 32'd1);
      check("stall_data", 32'(dout), 32'(prev_dout));
    end
    if (dout_valid === 1'b1 && rdy && exp_q.size() != 0) begin
      exp = exp_q.pop_front();
      check("data_order", 32'(dout), 32'(exp));
    end
    prev_stall = (dout_valid === 1'b1) && !rdy;
    prev_dout  = dout;
    dout_ready = rdy;
    @(negedge rclk);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 100; i++) begin
      if (exp_q.size() == 0) break;
      cycle(1'b1);
    end
    check(tag, 32'(exp_q.size()), 32'd0);
    cycle(1'b0);
    check({tag, "_valid_low"}, 32'(dout_valid), 32'd0);
    check({tag, "_empty"}, 32'(rempty), 32'd1);
  endtask

  initial begin
    // reset then idle
    rrst = 1'b1;
    wptr = '0;
    dout_ready = 1'b0;
    wcnt = '0;
    prev_stall = 1'b0;
    prev_dout = '0;
    repeat (3) @(negedge rclk);
    check("rst_rempty", 32'(rempty), 32'd1);
    check("rst_valid", 32'(dout_valid), 32'd0);
    check("rst_rptr", 32'(rptr), 32'd0);
    check("rst_raddr", 32'(raddr), 32'd0);
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_rlevel", 32'(rlevel), 32'd0);
    rrst = 1'b0;
    @(negedge rclk);

    // single word: valid exactly 4 edges after wptr moves
    wr_word(8'hA5);
    repeat (3) cycle(1'b0);
    check("lat_valid_early", 32'(dout_valid), 32'd0);
    check("lat_rempty_fall", 32'(rempty), 32'd0);
    cycle(1'b0);
    check("lat_valid", 32'(dout_valid), 32'd1);
    check("lat_dout", 32'(dout), 32'hA5);
    check("lat_rptr", 32'(rptr), 32'h01);
    check("lat_rempty", 32'(rempty), 32'd1);
    cycle(1'b1);
    cycle(1'b0);
    check("single_valid_low", 32'(dout_valid), 32'd0);

    // backpressure: three words, stalled, then streamed back to back
    wr_word(8'h11); cycle(1'b0);
    wr_word(8'h22); cycle(1'b0);
    wr_word(8'h33); cycle(1'b0);
    repeat (5) cycle(1'b0);
    check("bp_hold_dout", 32'(dout), 32'h11);
    for (int i = 0; i < 3; i++) begin
      check("bp_b2b_valid", 32'(dout_valid), 32'd1);
      cycle(1'b1);
    end
    check("bp_valid_drop", 32'(dout_valid), 32'd0);
    check("bp_queue", 32'(exp_q.size()), 32'd0);

    // wrap: 20 words streamed with ready held high
    n_wr = 0;
    saw_wrap = 1'b0;
    msb_toggles = 0;
    prev_raddr = raddr;
    prev_msb = rptr[4];
    for (int i = 0; i < 80; i++) begin
      if (n_wr < 20 && exp_q.size() < 16) begin
        wr_word(8'(32'h40 + n_wr));
        n_wr++;
      end
      cycle(1'b1);
      if (prev_raddr == 4'd15 && raddr == 4'd0) saw_wrap = 1'b1;
      if (rptr[4] !== prev_msb) msb_toggles++;
      prev_raddr = raddr;
      prev_msb = rptr[4];
      if (n_wr == 20 && exp_q.size() == 0) break;
    end
    check("wrap_written", 32'(n_wr), 32'd20);
    check("wrap_drained", 32'(exp_q.size()), 32'd0);
    check("wrap_raddr_15_0", 32'(saw_wrap), 32'd1);
    check("wrap_msb_toggles", 32'(msb_toggles), 32'd1);
    cycle(1'b0);
    check("wrap_rempty", 32'(rempty), 32'd1);
    check("wrap_valid", 32'(dout_valid), 32'd0);
    check("wrap_raddr", 32'(raddr), 32'(wcnt[3:0]));
    check("wrap_rptr", 32'(rptr), 32'(gray5(wcnt)));

    // full then drain: 16 words, one parked in dout, 15 left in memory
    for (int i = 0; i < 16; i++) begin
      wr_word(8'($urandom_range(0, 255)));
      cycle(1'b0);
    end
    repeat (4) cycle(1'b0);
    check("full_valid", 32'(dout_valid), 32'd1);
    check("full_rempty", 32'(rempty), 32'd0);
    check("full_rlevel", 32'(rlevel), exp_level(15));
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1);
      unread = (exp_q.size() > 0) ? exp_q.size() - 1 : 0;
      check("drain_rlevel", 32'(rlevel), exp_level(unread));
      check("drain_valid", 32'(dout_valid), 32'(exp_q.size() > 0));
      check("drain_rempty", 32'(rempty), 32'(exp_q.size() <= 1));
    end

    // randomized writes and consumer backpressure
    for (int i = 0; i < 300; i++) begin
      if (exp_q.size() < 16 && $urandom_range(0, 1) == 1) wr_word(8'($urandom_range(0, 255)));
      cycle($urandom_range(0, 3) != 0);
    end
    drain("rand_drain");

    // reset mid-stream: output register discarded before the next edge
    wr_word(8'h5A); cycle(1'b0);
    wr_word(8'hC6); cycle(1'b0);
    repeat (5) cycle(1'b0);
    check("mid_valid_before", 32'(dout_valid), 32'd1);
    rrst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(dout_valid), 32'd0);
    check("mid_rst_rptr", 32'(rptr), 32'd0);
    check("mid_rst_raddr", 32'(raddr), 32'd0);
    check("mid_rst_rempty", 32'(rempty), 32'd1);
    check("mid_rst_dout", 32'(dout), 32'd0);
    exp_q.delete();
    wcnt = '0;
    wptr = '0;
    prev_stall = 1'b0;
    dout_ready = 1'b0;
    repeat (2) @(negedge rclk);
    rrst = 1'b0;
    @(negedge rclk);
    wr_word(8'hC3);
    repeat (4) cycle(1'b0);
    check("post_rst_valid", 32'(dout_valid), 32'd1);
    check("post_rst_dout", 32'(dout), 32'hC3);
    drain("post_rst_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
